// File: rtl/zx81_tape_player.sv
// zx81_tape_player: replays a buffered tape image as ZX81 EAR pulse trains
// Ports:
//   clk_sys   - system clock, all logic on the rising edge
//   reset_n   - synchronous reset, active low
//   start     - one-cycle strobe, begins playback from address 0 (needs play=1)
//   play      - 1 runs playback, 0 freezes it with tape_out held low
//   tape_size - number of image bytes, captured on the accepted start
//   rd_addr   - buffer read address
//   rd_data   - buffer data, valid one cycle after rd_addr
//   tape_out  - generated tape signal
//   busy      - high from the accepted start until DONE
//   done      - one-cycle pulse at the end of playback
//   byte_pos  - index of the image byte currently being sent
module zx81_tape_player #(
    parameter int          CLK_MHZ   = 52,
    parameter int          PULSE_US  = 150,
    parameter int          GAP_US    = 1300,
    parameter int          LEADER_US = 500000,
    parameter logic [7:0]  NAME_BYTE = 8'hA6
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        play,
    input  logic [15:0] tape_size,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] byte_pos
);
    localparam int MAXD = LEADER_US > GAP_US ? (LEADER_US > PULSE_US ? LEADER_US : PULSE_US)
                                             : (GAP_US > PULSE_US ? GAP_US : PULSE_US);
    localparam int TW = $clog2(MAXD + 1);
    localparam int PW = $clog2(CLK_MHZ + 1);
    typedef enum logic [2:0] {IDLE, LEADER, FETCH, LOAD, PULSE_HI, PULSE_LO, GAP, DONE} state_t;
    state_t        state, state_n;
    logic [PW-1:0] presc;
    logic [TW-1:0] timer, dur;
    logic [7:0]    sr;
    logic [2:0]    bit_cnt;
    logic [3:0]    pulse_cnt;
    logic          is_name, run, tick, expire, last_pulse, end_tape;
    logic [15:0]   size, pos_n;
    assign busy       = state != IDLE && state != DONE;
    assign done       = state == DONE;
    assign tape_out   = state == PULSE_HI && play;
    // a paused player freezes every register; IDLE and DONE are never paused
    assign run        = play || !busy;
    assign tick       = presc == PW'(CLK_MHZ - 1);
    assign dur        = state == LEADER ? TW'(LEADER_US) : state == GAP ? TW'(GAP_US) : TW'(PULSE_US);
    assign expire     = tick && timer == dur - TW'(1);
    assign last_pulse = pulse_cnt == (sr[7] ? 4'd8 : 4'd3);
    // after the name byte the image starts at 0; an empty image then ends at once
    assign pos_n      = is_name ? 16'd0 : byte_pos + 16'd1;
    assign end_tape   = pos_n == size;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start && play) state_n = LEADER;
            LEADER:   if (expire) state_n = LOAD;
            FETCH:    state_n = LOAD;
            LOAD:     state_n = PULSE_HI;
            PULSE_HI: if (expire) state_n = PULSE_LO;
            PULSE_LO: if (expire) state_n = last_pulse ? GAP : PULSE_HI;
            GAP:      if (expire) state_n = bit_cnt != 3'd0 ? PULSE_HI : end_tape ? DONE : FETCH;
            default:  state_n = IDLE;
        endcase
        if (!run) state_n = state;
    end
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= IDLE;
            presc     <= '0;
            timer     <= '0;
            sr        <= '0;
            bit_cnt   <= '0;
            pulse_cnt <= '0;
            is_name   <= 1'b0;
            size      <= '0;
            byte_pos  <= '0;
            rd_addr   <= '0;
        end else if (run) begin
            state <= state_n;
            presc <= (state_n != state || tick) ? '0 : presc + PW'(1);
            timer <= state_n != state ? '0 : tick ? timer + TW'(1) : timer;
            if (state == IDLE && state_n == LEADER) begin
                byte_pos <= '0;
                size     <= tape_size;
            end
            if (state == LEADER && expire) begin
                sr      <= NAME_BYTE;
                is_name <= 1'b1;
            end
            if (state == LOAD) begin
                if (!is_name) sr <= rd_data;
                bit_cnt   <= 3'd7;
                pulse_cnt <= '0;
            end
            if (state == PULSE_LO && expire) pulse_cnt <= pulse_cnt + 4'd1;
            if (state == GAP && expire) begin
                pulse_cnt <= '0;
                if (bit_cnt != 3'd0) begin
                    sr      <= {sr[6:0], 1'b0};
                    bit_cnt <= bit_cnt - 3'd1;
                end else begin
                    is_name  <= 1'b0;
                    byte_pos <= pos_n;
                end
            end
            // address is registered on FETCH entry so the RAM sees it during FETCH
            if (state != FETCH && state_n == FETCH) rd_addr <= pos_n;
        end
    end
endmodule

// File: tb/tb_zx81_tape_player.sv
// tb_zx81_tape_player: directed self-checking bench for zx81_tape_player
module tb_zx81_tape_player;
    logic        clk_sys = 1'b0, reset_n = 1'b0, start = 1'b0, play = 1'b1;
    logic [15:0] tape_size = 16'd0;
    logic [15:0] rd_addr, byte_pos;
    logic [7:0]  rd_data;
    logic        tape_out, busy, done;
    int          checks = 0, passed = 0;
    logic [7:0]  mem [0:3];
    logic        wave[$], expw[$];
    logic [15:0] addrs[$];
    bit          got_done, aborted, first_busy, done_busy, after_done;
    int          pause_busy_bad;
    logic        rs_tape, rs_busy, rs_done;
    logic [15:0] rs_pos, rs_addr, done_pos;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) rd_data <= mem[rd_addr[1:0]];

    zx81_tape_player #(.CLK_MHZ(2), .PULSE_US(3), .GAP_US(20), .LEADER_US(50)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .play(play),
        .tape_size(tape_size), .rd_addr(rd_addr), .rd_data(rd_data),
        .tape_out(tape_out), .busy(busy), .done(done), .byte_pos(byte_pos)
    );

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            repeat (b[i] ? 9 : 4) begin
                repeat (6) expw.push_back(1'b1);
                repeat (6) expw.push_back(1'b0);
            end
            repeat (40) expw.push_back(1'b0);
        end
    endtask

    task automatic build_exp(input int n);
        expw.delete();
        repeat (101) expw.push_back(1'b0);
        add_byte(8'hA6);
        for (int k = 0; k < n; k++) begin
            repeat (2) expw.push_back(1'b0);
            add_byte(mem[k]);
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < wave.size() || i < expw.size(); i++)
            if (i >= wave.size() || i >= expw.size() || wave[i] !== expw[i]) return i;
        return -1;
    endfunction

    function automatic int rises();
        int n = 0;
        for (int i = 1; i < wave.size(); i++) if (wave[i] && !wave[i-1]) n++;
        return n;
    endfunction

    function automatic int first_high();
        for (int i = 0; i < wave.size(); i++) if (wave[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic play_run(input int pause_at, input int pause_len, input int restart_at, input int rst_at);
        wave.delete();
        addrs.delete();
        got_done = 0;
        aborted = 0;
        pause_busy_bad = 0;
        @(negedge clk_sys);
        start = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_sys);
            start = 1'b0;
            if (done) begin
                got_done = 1;
                break;
            end
            if (i == 0) first_busy = busy;
            wave.push_back(tape_out);
            addrs.push_back(rd_addr);
            if (i == restart_at) start = 1'b1;
            if (i == pause_at) begin
                play = 1'b0;
                repeat (pause_len) begin
                    @(negedge clk_sys);
                    wave.push_back(tape_out);
                    addrs.push_back(rd_addr);
                    if (!busy) pause_busy_bad++;
                end
                play = 1'b1;
            end
            if (i == rst_at) begin
                reset_n = 1'b0;
                @(negedge clk_sys);
                {rs_tape, rs_busy, rs_done, rs_pos, rs_addr} = {tape_out, busy, done, byte_pos, rd_addr};
                reset_n = 1'b1;
                aborted = 1;
                break;
            end
        end
        if (got_done) begin
            done_busy = busy;
            done_pos = byte_pos;
            @(negedge clk_sys);
            after_done = done;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        play = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            start = 1'b0;
            checks++;
            if ({tape_out, busy, done, rd_addr, byte_pos} !== 35'd0)
                $display("FAIL reset cycle %0d: tape_out=%b busy=%b done=%b rd_addr=%0d byte_pos=%0d, want all 0", i, tape_out, busy, done, rd_addr, byte_pos);
            else passed++;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_name_only();
        int d;
        int chg = 0;
        tape_size = 16'd0;
        play_run(-1, 0, -1, -1);
        build_exp(0);
        d = first_diff();
        foreach (addrs[i]) if (addrs[i] !== 16'd0) chg++;
        checks++; if (!got_done) $display("FAIL name_done: no done within budget"); else passed++;
        checks++; if (wave.size() !== 1045) $display("FAIL name_len: got %0d cycles, want 1045", wave.size()); else passed++;
        checks++; if (d !== -1) $display("FAIL name_wave: first mismatch at cycle %0d, want none", d); else passed++;
        checks++; if (rises() !== 52) $display("FAIL name_pulses: got %0d, want 52", rises()); else passed++;
        checks++; if (chg !== 0) $display("FAIL name_rd_addr: %0d cycles with rd_addr!=0, want 0", chg); else passed++;
        checks++; if (first_busy !== 1'b1) $display("FAIL name_busy: got %b, want 1", first_busy); else passed++;
        checks++; if ({done_busy, after_done} !== 2'b00) $display("FAIL name_done_pulse: busy@done=%b done_next=%b, want 0 0", done_busy, after_done); else passed++;
        checks++; if (done_pos !== 16'd0) $display("FAIL name_byte_pos: got %0d, want 0", done_pos); else passed++;
    endtask

    task automatic test_two_bytes();
        int d;
        int a1 = -1;
        tape_size = 16'd2;
        play_run(-1, 0, -1, -1);
        build_exp(2);
        d = first_diff();
        foreach (addrs[i]) if (addrs[i] === 16'd1 && a1 < 0) a1 = i;
        checks++; if (!got_done) $display("FAIL two_done: no done within budget"); else passed++;
        checks++; if (wave.size() !== 2937) $display("FAIL two_len: got %0d cycles, want 2937", wave.size()); else passed++;
        checks++; if (d !== -1) $display("FAIL two_wave: first mismatch at cycle %0d, want none", d); else passed++;
        checks++; if (rises() !== 156) $display("FAIL two_pulses: got %0d, want 156", rises()); else passed++;
        checks++; if (a1 !== 1751) $display("FAIL two_rd_addr1: rd_addr=1 first at %0d, want 1751", a1); else passed++;
        checks++; if (done_pos !== 16'd2) $display("FAIL two_byte_pos: got %0d, want 2", done_pos); else passed++;
        checks++; if (after_done !== 1'b0) $display("FAIL two_done_pulse: done next cycle %b, want 0", after_done); else passed++;
    endtask

    task automatic test_pause();
        int d;
        play_run(103, 37, -1, -1);
        build_exp(2);
        for (int k = 0; k < 37; k++) expw.insert(104, 1'b0);
        d = first_diff();
        checks++; if (wave.size() !== 2974) $display("FAIL pause_len: got %0d cycles, want 2974", wave.size()); else passed++;
        checks++; if (d !== -1) $display("FAIL pause_wave: first mismatch at cycle %0d, want none", d); else passed++;
        checks++;
        if ({wave[103], wave[141], wave[142], wave[143], wave[144]} !== 5'b11110)
            $display("FAIL pause_resume: got %b%b%b%b%b, want 11110", wave[103], wave[141], wave[142], wave[143], wave[144]);
        else passed++;
        checks++; if (pause_busy_bad !== 0) $display("FAIL pause_busy: %0d paused cycles with busy=0, want 0", pause_busy_bad); else passed++;
    endtask

    task automatic test_start_ignored();
        play_run(-1, 0, 30, -1);
        checks++; if (first_high() !== 101) $display("FAIL restart_first_edge: got %0d, want 101", first_high()); else passed++;
        checks++; if (wave.size() !== 2937) $display("FAIL restart_len: got %0d cycles, want 2937", wave.size()); else passed++;
        @(negedge clk_sys);
        play = 1'b0;
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        repeat (2) @(negedge clk_sys);
        play = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++; if ({busy, tape_out} !== 2'b00) $display("FAIL start_no_play: busy=%b tape_out=%b, want 0 0", busy, tape_out); else passed++;
    endtask

    task automatic test_reset_mid_byte();
        int d;
        play_run(-1, 0, -1, 1754);
        checks++; if (!aborted || wave[1754] !== 1'b1) $display("FAIL rst_setup: aborted=%b tape_out=%b, want 1 1", aborted, wave[1754]); else passed++;
        checks++;
        if ({rs_tape, rs_busy, rs_done, rs_pos, rs_addr} !== 35'd0)
            $display("FAIL rst_mid: tape_out=%b busy=%b done=%b byte_pos=%0d rd_addr=%0d, want all 0", rs_tape, rs_busy, rs_done, rs_pos, rs_addr);
        else passed++;
        play_run(-1, 0, -1, -1);
        build_exp(2);
        d = first_diff();
        checks++; if (wave.size() !== 2937) $display("FAIL rst_replay_len: got %0d cycles, want 2937", wave.size()); else passed++;
        checks++; if (d !== -1) $display("FAIL rst_replay_wave: first mismatch at cycle %0d, want none", d); else passed++;
        checks++; if (done_pos !== 16'd2) $display("FAIL rst_replay_byte_pos: got %0d, want 2", done_pos); else passed++;
    endtask

    initial begin
        mem[0] = 8'h00;
        mem[1] = 8'hFF;
        mem[2] = 8'h5A;
        mem[3] = 8'hC3;
        test_reset();
        test_name_only();
        test_two_bytes();
        test_pause();
        test_start_ignored();
        test_reset_mid_byte();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
